// File: rtl/apb_slave.sv
// apb_slave: APB completer with a register bank, fixed wait states and address-error response
module apb_slave #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        PRESET,
  input  logic        PSEL1,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic wr_q, err_q;
  logic [AW-1:0] idx_q;
  logic [31:0] wdata_q;
  logic [31:0] regs [DEPTH];
  logic setup, err_in, ld, clr, lat, we, ld_err, ld_rd;
  logic [AW-1:0] idx_in, ld_idx;
  logic [31:0] ld_data;
  assign setup   = PSEL1 && !PENABLE;
  assign err_in  = (PADDR[1:0] != 2'b00) || (PADDR >= 32'(4 * DEPTH));
  assign idx_in  = PADDR[AW+1:2];
  // zero-wait responses are loaded on the setup edge, so they come from the live bus
  assign ld_err  = state == IDLE ? err_in : err_q;
  assign ld_rd   = state == IDLE ? !PWRITE : !wr_q;
  assign ld_idx  = state == IDLE ? idx_in : idx_q;
  assign ld_data = ld_rd && !ld_err ? regs[ld_idx] : 32'h0;
  assign we      = clr && wr_q && !err_q;
  // next state, wait counting, response load and completion strobes
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ld      = 1'b0;
    clr     = 1'b0;
    lat     = 1'b0;
    if (state == IDLE) begin
      if (setup) begin
        state_n = ACCESS;
        cnt_n   = 4'(WAIT_CYCLES);
        lat     = 1'b1;
        ld      = WAIT_CYCLES == 0;
      end
    end else if (PREADY) begin
      state_n = IDLE;
      clr     = 1'b1;
    end else if (!PSEL1 || !PENABLE) begin
      state_n = IDLE;
    end else begin
      cnt_n = cnt - 4'd1;
      ld    = cnt == 4'd1;
    end
  end
  // state register and registered response outputs
  always_ff @(posedge clk) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      PREADY  <= 1'b0;
      PRDATA  <= 32'h0;
      PSLVERR <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      PREADY  <= ld ? 1'b1 : clr ? 1'b0 : PREADY;
      PRDATA  <= ld ? ld_data : clr ? 32'h0 : PRDATA;
      PSLVERR <= ld ? ld_err : clr ? 1'b0 : PSLVERR;
    end
  end
  // transfer attributes captured at the setup edge
  always_ff @(posedge clk) begin
    if (lat) begin
      wr_q    <= PWRITE;
      err_q   <= err_in;
      idx_q   <= idx_in;
      wdata_q <= PWDATA;
    end
  end
  // register bank, written only on the completion edge of a clean write
  always_ff @(posedge clk) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= 32'h0;
    end else if (we) begin
      regs[idx_q] <= wdata_q;
    end
  end
endmodule

// File: tb/tb_apb_slave.sv
// tb_apb_slave: zero-wait and two-wait completers on a shared bus against a transfer-level model
module tb_apb_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic PRESET, PSEL1, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic rdy [2];
  logic er [2];
  logic [31:0] rdat [2];
  apb_slave #(.DEPTH(16), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .PRESET(PRESET), .PSEL1(PSEL1), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(rdy[0]), .PRDATA(rdat[0]), .PSLVERR(er[0]));
  apb_slave #(.DEPTH(16), .WAIT_CYCLES(2)) u1 (
    .clk(clk), .PRESET(PRESET), .PSEL1(PSEL1), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(rdy[1]), .PRDATA(rdat[1]), .PSLVERR(er[1]));
  int checks = 0, failures = 0;
  bit live = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  // transfer-level model: each transfer is timed from the cycle number of its setup edge
  logic [31:0] m [2][16];
  bit busy [2];
  int t0 [2];
  logic xw [2];
  logic [31:0] xa [2], xd [2];
  logic e_rdy [2], e_err [2];
  logic [31:0] e_rd [2];
  int n = 0;
  function automatic logic bad(input logic [31:0] a);
    return a[1:0] != 2'b00 || a >= 32'd64;
  endfunction
  function automatic logic [32:0] resp(input int k, input logic w, input logic [31:0] a);
    return {bad(a), (!w && !bad(a)) ? m[k][a[5:2]] : 32'h0};
  endfunction
  function automatic int wt(input int k);
    return k == 0 ? 0 : 2;
  endfunction
  always @(posedge clk) begin
    n <= n + 1;
    for (int k = 0; k < 2; k++) begin
      if (PRESET) begin
        busy[k] <= 1'b0;
        e_rdy[k] <= 1'b0;
        e_rd[k] <= 32'h0;
        e_err[k] <= 1'b0;
        for (int j = 0; j < 16; j++) m[k][j] <= 32'h0;
      end else if (busy[k]) begin
        if (n == t0[k] + wt(k) + 1) begin
          if (xw[k] && !bad(xa[k])) m[k][xa[k][5:2]] <= xd[k];
          busy[k] <= 1'b0;
          e_rdy[k] <= 1'b0;
          e_rd[k] <= 32'h0;
          e_err[k] <= 1'b0;
        end else if (!PSEL1 || !PENABLE) begin
          busy[k] <= 1'b0;
        end else if (n == t0[k] + wt(k)) begin
          {e_err[k], e_rd[k]} <= resp(k, xw[k], xa[k]);
          e_rdy[k] <= 1'b1;
        end
      end else if (PSEL1 && !PENABLE) begin
        busy[k] <= 1'b1;
        t0[k] <= n;
        xw[k] <= PWRITE;
        xa[k] <= PADDR;
        xd[k] <= PWDATA;
        if (wt(k) == 0) begin
          {e_err[k], e_rd[k]} <= resp(k, PWRITE, PADDR);
          e_rdy[k] <= 1'b1;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (live) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("pready%0d@%0d", k, n), 32'(rdy[k]), 32'(e_rdy[k]));
        chk($sformatf("prdata%0d@%0d", k, n), rdat[k], e_rd[k]);
        chk($sformatf("pslverr%0d@%0d", k, n), 32'(er[k]), 32'(e_err[k]));
      end
    end
  end
  // master paced by the two-wait completer; mode 1 aborts and mode 2 resets in the first wait cycle
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input int mode,
                      input logic b2b, output logic [31:0] rd, output logic e, output int waits,
                      output logic r0, output logic [31:0] rd0);
    PSEL1 = 1'b1;
    PENABLE = 1'b0;
    PWRITE = wr;
    PADDR = a;
    PWDATA = d;
    @(posedge clk);
    #1;
    PENABLE = 1'b1;
    rd = 32'h0;
    e = 1'b0;
    waits = -1;
    r0 = rdy[0];
    rd0 = rdat[0];
    for (int i = 0; i < 40; i++) begin
      if (mode != 0) begin
        if (mode == 2) PRESET = 1'b1;
        PSEL1 = 1'b0;
        PENABLE = 1'b0;
        @(posedge clk);
        #1;
        PRESET = 1'b0;
        return;
      end
      if (rdy[1]) begin
        rd = rdat[1];
        e = er[1];
        waits = i;
        @(posedge clk);
        #1;
        PENABLE = 1'b0;
        PSEL1 = b2b;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("xfer_completed_waits", 32'(waits), 32'(wt(1)));
  endtask
  logic [31:0] rd, rd0, a;
  logic e, r0;
  int w;
  initial begin
    PRESET = 1'b1;
    PSEL1 = 1'b0;
    PENABLE = 1'b0;
    PWRITE = 1'b0;
    PADDR = 32'h0;
    PWDATA = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    PRESET = 1'b0;
    live = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_pready", 32'(rdy[k]), 32'h0);
      chk("reset_prdata", rdat[k], 32'h0);
      chk("reset_pslverr", 32'(er[k]), 32'h0);
    end
    xfer(1'b0, 32'h0, 32'h0, 0, 1'b0, rd, e, w, r0, rd0);
    chk("read0_data", rd, 32'h0);
    chk("read0_err", 32'(e), 32'h0);
    xfer(1'b1, 32'h8, 32'hDEADBEEF, 0, 1'b1, rd, e, w, r0, rd0);
    chk("write8_waits", 32'(w), 32'd2);
    xfer(1'b0, 32'h8, 32'h0, 0, 1'b0, rd, e, w, r0, rd0);
    chk("read8_data", rd, 32'hDEADBEEF);
    chk("read8_err", 32'(e), 32'h0);
    chk("read8_waits", 32'(w), 32'd2);
    chk("model_reg2", m[1][2], 32'hDEADBEEF);
    xfer(1'b1, 32'h0, 32'h11, 0, 1'b1, rd, e, w, r0, rd0);
    chk("zw_write_ready_first", 32'(r0), 32'h1);
    xfer(1'b0, 32'h0, 32'h0, 0, 1'b1, rd, e, w, r0, rd0);
    chk("zw_read_ready_first", 32'(r0), 32'h1);
    chk("zw_read_data", rd0, 32'h11);
    chk("w2_read0_data", rd, 32'h11);
    for (int i = 0; i < 2; i++) begin
      a = i == 0 ? 32'h42 : 32'h40;
      xfer(1'b1, a, 32'h5, 0, 1'b1, rd, e, w, r0, rd0);
      chk("err_write_flag", 32'(e), 32'h1);
      chk("err_write_data", rd, 32'h0);
      xfer(1'b0, a, 32'h0, 0, 1'b1, rd, e, w, r0, rd0);
      chk("err_read_flag", 32'(e), 32'h1);
      chk("err_read_data", rd, 32'h0);
    end
    xfer(1'b0, 32'h0, 32'h0, 0, 1'b0, rd, e, w, r0, rd0);
    chk("after_err_reg0", rd, 32'h11);
    xfer(1'b1, 32'h4, 32'hAA, 1, 1'b0, rd, e, w, r0, rd0);
    xfer(1'b0, 32'h4, 32'h0, 0, 1'b0, rd, e, w, r0, rd0);
    chk("abort_reg1_kept", rd, 32'h0);
    chk("abort_zw_completed", rd0, 32'hAA);
    xfer(1'b1, 32'hC, 32'h77, 0, 1'b0, rd, e, w, r0, rd0);
    xfer(1'b1, 32'hC, 32'h99, 2, 1'b0, rd, e, w, r0, rd0);
    chk("midreset_pready", 32'(rdy[1]), 32'h0);
    chk("midreset_prdata", rdat[1], 32'h0);
    chk("midreset_pslverr", 32'(er[1]), 32'h0);
    xfer(1'b0, 32'hC, 32'h0, 0, 1'b0, rd, e, w, r0, rd0);
    chk("midreset_regC", rd, 32'h0);
    chk("midreset_regC_zw", rd0, 32'h0);
    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(0, 2)) begin
        PSEL1 = 1'($urandom);
        PENABLE = 1'b1;
        @(posedge clk);
        #1;
      end
      case ($urandom_range(0, 9))
        0: a = 32'($urandom_range(0, 127));
        1: a = {$urandom_range(16, 31), 2'b00};
        2: a = {$urandom, 2'b00} | 32'h100;
        default: a = {$urandom_range(0, 15), 2'b00};
      endcase
      w = $urandom_range(0, 19);
      xfer(1'($urandom), a, $urandom, w == 0 ? 1 : w == 1 ? 2 : 0, 1'($urandom), rd, e, w, r0, rd0);
    end
    PSEL1 = 1'b0;
    PENABLE = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_slave.md
# apb_slave

APB completer (slave) that answers the transfers issued on the team's APB interface. It holds a bank of 32-bit registers and inserts a fixed, parameterised number of wait states through PREADY. PSLVERR flags misaligned or out-of-range addresses. It sits at the far end of the interface from the driver and is the DUT whose PREADY/PRDATA/PSLVERR the output monitor samples.

## Interface
- DEPTH, 16: number of 32-bit registers; legal, 1..256; byte address range 0 .. 4*DEPTH-1
- WAIT_CYCLES, 2: wait states inserted per access; legal, 0..15
- clk  input  1  clock; all activity on the rising edge
- PRESET  input  1  reset; one clock, synchronous, active-high
- PSEL1  input  1  slave select
- PENABLE  input  1  access-phase strobe
- PWRITE  input  1  1 = write, 0 = read
- PADDR  input  32  byte address
- PWDATA  input  32  write data
- PREADY  output  1  transfer completes in a cycle where PENABLE=1 and PREADY=1
- PRDATA  output  32  read data, valid while PREADY=1 on a read
- PSLVERR  output  1  error response, valid only while PREADY=1

## Operation
- FSM states: IDLE, ACCESS. Wait counter cnt is 4 bits.
- Address check:
  - err = (PADDR[1:0] != 0) OR (PADDR >= 4*DEPTH).
  - Register index = PADDR[9:2] when err = 0.
- IDLE:
  - Setup is PSEL1=1 and PENABLE=0.
  - On a setup edge: go to ACCESS, latch PWRITE/PADDR/PWDATA/err, set cnt <= WAIT_CYCLES.
  - If WAIT_CYCLES=0, also set PREADY <= 1 and load response.
  - PENABLE=1 without a preceding setup is ignored.
- ACCESS with PREADY=0:
  - If PSEL1=0 or PENABLE=0 (master aborted): go to IDLE, no write, outputs unchanged at 0.
  - Otherwise decrement cnt. When cnt=1, set PREADY <= 1 and load response.
- Response load:
  - PSLVERR <= err.
  - PRDATA <= (read and !err) ? reg[index] : 0.
  - Writes leave PRDATA at 0.
- ACCESS with PREADY=1 (completion edge):
  - Write register if write and !err.
  - PREADY <= 0, PSLVERR <= 0, PRDATA <= 0, go to IDLE.
  - An errored write never modifies any register.
- Registers are read/write, 32 bits, no byte strobes.
- Back-to-back transfers: a new setup one cycle after completion (PSEL1 held high, PENABLE low) is accepted normally.
- Reset (PRESET=1 at any edge, including mid-transfer):
  - State IDLE, cnt=0, all registers 0.
  - PREADY=0, PRDATA=0, PSLVERR=0.
  - The pending transfer is dropped and any write is lost.
  - Reset wins over all other events on the same edge.

## Timing
- Edge E0 samples setup. The master drives PENABLE=1 from E0.
- PREADY is low for exactly WAIT_CYCLES access cycles, then high for one cycle.
- Completion edge = E0 + WAIT_CYCLES + 1. Minimum transfer is 2 cycles (setup + access).
- PREADY, PRDATA and PSLVERR are registered; no combinational input-to-output paths.
- PREADY never goes high outside ACCESS. It is high for exactly one cycle per transfer.
- PRDATA/PSLVERR change only on the edge that raises PREADY and the edge that lowers it.
- A written value is readable by the very next transfer (no hazard).
- With the master rules checked on the interface, PENABLE falls exactly one cycle after PREADY rises. PENABLE never falls while PREADY is low.

## Test plan
- Reset then idle: PRESET high 2 cycles -> PREADY=0, PRDATA=0, PSLVERR=0. A read of 0x0 returns 0x00000000 with PSLVERR=0.
- Write/read, WAIT_CYCLES=2: write 0xDEADBEEF to 0x8, then read 0x8 -> PREADY low 2 access cycles then high 1. Read returns 0xDEADBEEF, PSLVERR=0, 4 cycles per transfer.
- Zero wait (WAIT_CYCLES=0), back-to-back: write 0x11 to 0x0, immediately read 0x0 -> PREADY=1 in the first access cycle of each transfer, PRDATA=0x00000011.
- Errors: write 0x5 to 0x42 (misaligned) and to 0x40 with DEPTH=16 (out of range) -> PSLVERR=1 with PREADY, no register changes. Reads there return PRDATA=0, PSLVERR=1.
- Abort: setup write 0xAA to 0x4, drop PSEL1 during the first wait cycle -> no PREADY pulse. A later read of 0x4 returns its previous value.
- Reset mid-access: assert PRESET during the wait phase of a write to 0xC -> outputs 0 next cycle, FSM IDLE. A read of 0xC returns 0.
